bip_acc_bank: RTL and testbench

Parametrised accumulator bank for the next-generation BIP datapath. It replaces the single 16-bit load-only accumulator with NUM_ACC signed accumulators that each perform load, add, subtract and clear in place. Every operation updates registered status flags. A small LIFO context stack saves and restores accumulators across interrupts and calls. The bank sits between the operand mux and the ALU/data-memory write path; the control unit drives it.

---
 rtl/bip_acc_pkg.sv | 23 ++
 rtl/bip_acc_alu.sv | 46 ++++
 rtl/bip_acc_bank.sv | 125 ++++++++++++
 tb/tb_bip_acc_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bip_acc_pkg.sv
// Shared types for the BIP accumulator bank: op encoding, flag bundle and a width helper.
// Pure declarations; no timing or flow control.
package bip_acc_pkg;

  typedef enum logic [1:0] {
    ACC_LOAD = 2'b00,
    ACC_ADD  = 2'b01,
    ACC_SUB  = 2'b10,
    ACC_CLR  = 2'b11
  } acc_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } acc_flags_t;

  // Index width for an n-entry array; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bip_acc_alu.sv
// Combinational load/add/sub/clear with signed overflow; zero latency, no flow control.
// BIP_ACC_SAT_EN defined: overflowing ADD/SUB clamp to the signed extreme, otherwise they wrap.
module bip_acc_alu
  import bip_acc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  acc_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] sum;

  assign a_x = {a[DATA_W-1], a};
  assign b_x = {b[DATA_W-1], b};

  always_comb begin
    sum = '0;
    res = '0;
    ovf = 1'b0;
    case (op)
      ACC_LOAD: res = b;
      ACC_ADD, ACC_SUB: begin
        sum = (op == ACC_ADD) ? (a_x + b_x) : (a_x - b_x);
        // One guard bit: the top two bits disagree exactly when the true result leaves range.
        ovf = sum[DATA_W] ^ sum[DATA_W-1];
`ifdef BIP_ACC_SAT_EN
        if (ovf) begin
          res = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
          res = sum[DATA_W-1:0];
        end
`else
        res = sum[DATA_W-1:0];
`endif
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/bip_acc_bank.sv
// NUM_ACC signed accumulators with shared ALU, status flags and a LIFO context stack; results one cycle after the command.
// Commands never stall (pop > push > en, collisions flag sticky err_o); saturation via BIP_ACC_SAT_EN.
module bip_acc_bank
  import bip_acc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_ACC     = 4,
  parameter int STACK_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [1:0]                 op_i,
  input  logic [$clog2(NUM_ACC)-1:0] sel_i,
  input  logic [DATA_W-1:0]          x_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clr_err_i,
  output logic [DATA_W-1:0]          y_o,
  output logic                       zero_o,
  output logic                       neg_o,
  output logic                       ovf_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       err_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = idx_w(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [DATA_W-1:0] acc_q [NUM_ACC];
  logic [DATA_W-1:0] stk_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  acc_flags_t        flg_q;
  logic              err_q;

  logic              full;
  logic              empty;
  logic              do_pop;
  logic              do_push;
  logic              do_op;
  logic              wr_en;
  logic              new_err;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [DATA_W-1:0] acc_sel;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic [DATA_W-1:0] wr_val;

  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - 1'b1);
  assign acc_sel  = acc_q[sel_i];

  // Only the highest-priority command may act; blocked push/pop leave all state alone.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & ~pop_i & ~full;
  assign do_op   = en_i & ~pop_i & ~push_i;
  assign wr_en   = do_pop | do_op;
  assign new_err = (pop_i & (push_i | en_i)) | (push_i & en_i)
                 | (pop_i & empty) | (push_i & ~pop_i & full);

  bip_acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op  (acc_op_e'(op_i)),
    .a   (acc_sel),
    .b   (x_i),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  assign wr_val = do_pop ? stk_q[pop_idx] : alu_res;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else if (wr_en) begin
      acc_q[sel_i] <= wr_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      sp_q <= '0;
    end else if (do_pop) begin
      sp_q <= sp_q - 1'b1;
    end else if (do_push) begin
      stk_q[push_idx] <= acc_sel;
      sp_q            <= sp_q + 1'b1;
    end
  end

  // LOAD and CLR report ovf=0 from the ALU, so ovf only needs masking on pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flg_q <= '{zero: 1'b1, neg: 1'b0, ovf: 1'b0};
    end else if (wr_en) begin
      flg_q <= '{zero: (wr_val == '0), neg: wr_val[DATA_W-1], ovf: do_op & alu_ovf};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (new_err) begin
      err_q <= 1'b1;
    end else if (clr_err_i) begin
      err_q <= 1'b0;
    end
  end

  assign y_o     = acc_sel;
  assign zero_o  = flg_q.zero;
  assign neg_o   = flg_q.neg;
  assign ovf_o   = flg_q.ovf;
  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bip_acc_bank.sv
// Directed scoreboard bench for bip_acc_bank; expected flags are packed {zero,neg,ovf,full,empty,err}.
module tb_bip_acc_bank;
  import bip_acc_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        en_i;
  logic [1:0]  op_i;
  logic [1:0]  sel_i;
  logic [15:0] x_i;
  logic        push_i;
  logic        pop_i;
  logic        clr_err_i;
  logic [15:0] y_o;
  logic        zero_o, neg_o, ovf_o, full_o, empty_o, err_o;

  bip_acc_bank #(.DATA_W(16), .NUM_ACC(4), .STACK_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .op_i(op_i), .sel_i(sel_i), .x_i(x_i),
    .push_i(push_i), .pop_i(pop_i), .clr_err_i(clr_err_i), .y_o(y_o), .zero_o(zero_o),
    .neg_o(neg_o), .ovf_o(ovf_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

`ifdef BIP_ACC_SAT_EN
  localparam logic [15:0] Y_A = 16'h7FFF; localparam logic [5:0] F_A = 6'b001_010;
  localparam logic [15:0] Y_B = 16'h7FFF; localparam logic [5:0] F_B = 6'b001_100;
  localparam logic [15:0] Y_C = 16'h8000; localparam logic [5:0] F_C = 6'b011_010;
`else
  localparam logic [15:0] Y_A = 16'h8010; localparam logic [5:0] F_A = 6'b011_010;
  localparam logic [15:0] Y_B = 16'hE000; localparam logic [5:0] F_B = 6'b011_100;
  localparam logic [15:0] Y_C = 16'h7FFF; localparam logic [5:0] F_C = 6'b001_010;
`endif

  typedef struct {
    string       name;
    logic [15:0] y;
    logic [5:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic cmd_vld = 1'b0;
  event async_ev;

  task automatic check_one();
    exp_t        e;
    logic [21:0] got;
    n_chk++;
    got = {y_o, zero_o, neg_o, ovf_o, full_o, empty_o, err_o};
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow: output presented with no expectation, got y=%h flags=%b", y_o, got[5:0]);
    end else begin
      e = exp_q.pop_front();
      if (got !== {e.y, e.f}) begin
        n_fail++;
        $display("FAIL %s: got y=%h flags=%b, expected y=%h flags=%b", e.name, y_o, got[5:0], e.y, e.f);
      end
    end
  endtask

  // Clocked monitor: a command driven in a cycle is checked just after the following edge.
  initial begin
    logic take;
    forever begin
      @(posedge clk);
      take = cmd_vld;
      #1;
      if (take) check_one();
    end
  end

  // Unclocked monitor for checks made while reset is held.
  initial begin
    forever begin
      @(async_ev);
      check_one();
    end
  end

  task automatic cmd(input string nm, input logic pu, input logic po, input logic en,
                     input logic ce, input logic [1:0] op, input logic [1:0] s,
                     input logic [15:0] x, input logic [15:0] ey, input logic [5:0] ef);
    exp_t e;
    @(negedge clk);
    push_i = pu; pop_i = po; en_i = en; clr_err_i = ce; op_i = op; sel_i = s; x_i = x;
    e.name = nm; e.y = ey; e.f = ef;
    exp_q.push_back(e);
    cmd_vld = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [1:0] s, input logic [15:0] ey, input logic [5:0] ef);
    cmd(nm, 1'b0, 1'b0, 1'b0, 1'b0, ACC_LOAD, s, 16'h0, ey, ef);
  endtask

  task automatic idle();
    @(negedge clk);
    push_i = 0; pop_i = 0; en_i = 0; clr_err_i = 0; op_i = 0; x_i = 0;
    cmd_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_ni = 1'b0; en_i = 0; op_i = 0; sel_i = 0; x_i = 0; push_i = 0; pop_i = 0; clr_err_i = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    for (int s = 0; s < 4; s++) rd("reset_read", 2'(s), 16'h0000, 6'b100_010);

    cmd("load_a1",   0, 0, 1, 0, ACC_LOAD, 2'd1, 16'h7FF0, 16'h7FF0, 6'b000_010);
    cmd("add_ovf",   0, 0, 1, 0, ACC_ADD,  2'd1, 16'h0020, Y_A,      F_A);
    cmd("load_a2",   0, 0, 1, 0, ACC_LOAD, 2'd2, 16'h0005, 16'h0005, 6'b000_010);
    cmd("sub_zero",  0, 0, 1, 0, ACC_SUB,  2'd2, 16'h0005, 16'h0000, 6'b100_010);
    rd("a0_untouched", 2'd0, 16'h0000, 6'b100_010);
    rd("a1_untouched", 2'd1, Y_A,      6'b100_010);
    rd("a3_untouched", 2'd3, 16'h0000, 6'b100_010);

    cmd("load_a0",   0, 0, 1, 0, ACC_LOAD, 2'd0, 16'h1234, 16'h1234, 6'b000_010);
    cmd("load_a3",   0, 0, 1, 0, ACC_LOAD, 2'd3, 16'hBEEF, 16'hBEEF, 6'b010_010);
    cmd("push_a0",   1, 0, 0, 0, ACC_LOAD, 2'd0, 16'h0,    16'h1234, 6'b010_000);
    cmd("push_full", 1, 0, 0, 0, ACC_LOAD, 2'd3, 16'h0,    16'hBEEF, 6'b010_100);
    cmd("push_ovr",  1, 0, 0, 0, ACC_LOAD, 2'd1, 16'h0,    Y_A,      6'b010_101);
    cmd("clr_err1",  0, 0, 0, 1, ACC_LOAD, 2'd2, 16'h0,    16'h0000, 6'b010_100);
    cmd("load_7000", 0, 0, 1, 0, ACC_LOAD, 2'd1, 16'h7000, 16'h7000, 6'b000_100);
    cmd("add_ovf2",  0, 0, 1, 0, ACC_ADD,  2'd1, 16'h7000, Y_B,      F_B);
    cmd("pop_a2",    0, 1, 0, 0, ACC_LOAD, 2'd2, 16'h0,    16'hBEEF, 6'b010_000);
    cmd("pop_a1",    0, 1, 0, 0, ACC_LOAD, 2'd1, 16'h0,    16'h1234, 6'b000_010);
    rd("a0_kept",  2'd0, 16'h1234, 6'b000_010);
    rd("a3_kept",  2'd3, 16'hBEEF, 6'b000_010);
    rd("a2_kept",  2'd2, 16'hBEEF, 6'b000_010);

    cmd("pop_empty", 0, 1, 0, 0, ACC_LOAD, 2'd3, 16'h0,    16'hBEEF, 6'b000_011);
    cmd("clr_err2",  0, 0, 0, 1, ACC_LOAD, 2'd0, 16'h0,    16'h1234, 6'b000_010);
    cmd("push_en",   1, 0, 1, 0, ACC_CLR,  2'd0, 16'h0,    16'h1234, 6'b000_001);
    cmd("pop_col",   1, 1, 0, 1, ACC_LOAD, 2'd2, 16'h0,    16'h1234, 6'b000_011);
    cmd("clr_err3",  0, 0, 0, 1, ACC_LOAD, 2'd2, 16'h0,    16'h1234, 6'b000_010);
    cmd("load_8000", 0, 0, 1, 0, ACC_LOAD, 2'd2, 16'h8000, 16'h8000, 6'b010_010);
    cmd("sub_ovf",   0, 0, 1, 0, ACC_SUB,  2'd2, 16'h0001, Y_C,      F_C);
    cmd("clr_a2",    0, 0, 1, 0, ACC_CLR,  2'd2, 16'hFFFF, 16'h0000, 6'b100_010);
    cmd("push_pre",  1, 0, 0, 0, ACC_LOAD, 2'd1, 16'h0,    16'h1234, 6'b100_000);

    // Reset asserted a couple of ns after the edge that performed the push.
    @(posedge clk);
    #2;
    cmd_vld = 1'b0; push_i = 0; en_i = 0;
    rst_ni = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_i = 2'(s);
      #1;
      e.name = "async_reset"; e.y = 16'h0000; e.f = 6'b100_010;
      exp_q.push_back(e);
      -> async_ev;
      #1;
    end
    @(negedge clk);
    rst_ni = 1'b1;

    rd("post_reset_a1", 2'd1, 16'h0000, 6'b100_010);
    cmd("post_reset_pop", 0, 1, 0, 0, ACC_LOAD, 2'd0, 16'h0, 16'h0000, 6'b100_011);
    idle();
    repeat (3) @(negedge clk);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
